time_entry_loader: RTL
======================

// Module: time_entry_loader
// PURPOSE
//  Keypad-side writer for the microwave timer's 4-bit down-counter chain (min_ones, sec_tens, sec_ones).
//  Collects BCD digit keystrokes into a 3-digit entry buffer and validates the value on start.
//  Drives the counters' parallel-load interface (active-low loadn, load data), then pulses start.
//  Stays in RUN until the chain reports zero or the user cancels.
// PARAMETERS
//  SEC_TENS_MAX  5  largest legal seconds-tens digit; start with a larger digit is rejected
//  MIN_MAX       9  largest legal minutes digit
// PORTS
//  clock        in   1  system clock; all state updates on the rising edge
//  clear        in   1  asynchronous, active-high reset
//  key_valid    in   1  one-cycle keystroke strobe
//  key_digit    in   4  keystroke code; 0-9 = digit, 10-15 = illegal
//  start        in   1  start key strobe
//  cancel       in   1  cancel key strobe
//  timer_zero   in   1  high when the whole counter chain reads 0:00
//  disp_min     out  4  entry buffer: minutes digit
//  disp_tens    out  4  entry buffer: seconds-tens digit
//  disp_ones    out  4  entry buffer: seconds-ones digit
//  load_min     out  4  load data to minutes counter
//  load_tens    out  4  load data to seconds-tens counter
//  load_ones    out  4  load data to seconds-ones counter
//  loadn        out  1  active-low parallel load to all three counters
//  run_en       out  1  counter enable; high throughout RUN
//  entry_err    out  1  one-cycle pulse: illegal key or rejected start
//  busy         out  1  high in LOAD and RUN
// BEHAVIOUR
//  Reset: state IDLE; disp_*/load_* = 0; digit count = 0; loadn = 1; run_en = 0; entry_err = 0; busy = 0.
//  States: IDLE, ENTRY, LOAD, RUN. Priority within one cycle: cancel > start > key_valid.
//  IDLE/ENTRY, legal digit with count < 3:
//   - Shift left: disp_min <= disp_tens, disp_tens <= disp_ones, disp_ones <= key_digit.
//   - count++; state becomes ENTRY.
//  Legal digit with count == 3: ignored; buffer unchanged; no error.
//  key_digit > 9: buffer unchanged; entry_err pulses on the following cycle.
//  start in IDLE/ENTRY:
//   - Buffer all zero: ignored, no error.
//   - disp_tens > SEC_TENS_MAX or disp_min > MIN_MAX: entry_err pulses; buffer and count clear; state IDLE.
//   - Otherwise: load_* <= disp_*; state LOAD.
//  LOAD: loadn = 0 for exactly one cycle with load_* stable; run_en = 0; next state RUN.
//  RUN: run_en = 1; loadn = 1. key_valid and start are ignored.
//   - timer_zero sampled high -> run_en drops the next cycle; buffer and count clear; state IDLE.
//   - timer_zero is not sampled in the LOAD cycle; sampling starts at the first RUN cycle.
//  cancel in any state: next cycle state IDLE; buffer, count and load_* clear; run_en = 0; loadn = 1.
//   - cancel in LOAD suppresses the load pulse if it has not yet been issued.
//  clear mid-operation: all outputs return to reset values immediately; loadn deasserts asynchronously.
//  Widths: all digits are 4-bit BCD; no arithmetic beyond compares; count is 2 bits and saturates at 3.
//  Outputs are registered; entry_err and loadn are never asserted together.
// TESTING
//  1) Keys 1,3,0 then start -> disp = 1:30; loadn low exactly one cycle with load = 1,3,0; run_en high from the next cycle.
//  2) Keys 2,7,5 then start -> entry_err one pulse; disp cleared to 0:00; state IDLE; loadn never low.
//  3) Keys 4,5,6,7 -> disp = 4:56 (4th digit ignored); key_digit = 12 -> entry_err pulse; buffer still 4:56.
//  4) Start with empty buffer -> no load, no error, state stays IDLE.
//  5) In RUN, assert timer_zero -> run_en low the next cycle, disp = 0:00, busy = 0; cancel in RUN -> same, with load_* = 0.
//  6) Assert clear asynchronously during LOAD -> loadn returns to 1 before the next clock edge; all outputs at reset values.
//     Also assert start and cancel in the same cycle -> cancel wins; no load.

Source files
------------

// File: rtl/time_entry_loader.sv
// Keypad entry buffer and load sequencer for the microwave timer's BCD down-counter chain.
// Collects up to three digits, validates on start, pulses the parallel load, then enables the count.
module time_entry_loader #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5,
    parameter logic [3:0] MIN_MAX      = 4'd9
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       cancel,
    input  logic       timer_zero,
    output logic [3:0] disp_min,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic [3:0] load_min,
    output logic [3:0] load_tens,
    output logic [3:0] load_ones,
    output logic       loadn,
    output logic       run_en,
    output logic       entry_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_LOAD,
        S_RUN
    } state_t;

    state_t     r_state;
    logic [3:0] r_disp_min, r_disp_tens, r_disp_ones;
    logic [3:0] r_load_min, r_load_tens, r_load_ones;
    logic [1:0] r_count;
    logic       r_loadn;
    logic       r_run_en;
    logic       r_entry_err;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [3:0] w_disp_min_nxt, w_disp_tens_nxt, w_disp_ones_nxt;
    logic [3:0] w_load_min_nxt, w_load_tens_nxt, w_load_ones_nxt;
    logic [1:0] w_count_nxt;
    logic       w_loadn_nxt;
    logic       w_run_en_nxt;
    logic       w_entry_err_nxt;
    logic       w_busy_nxt;

    logic       w_key_legal;
    logic       w_buf_zero;
    logic       w_reject;

    assign w_key_legal = (key_digit <= 4'd9);
    assign w_buf_zero  = (r_disp_min == '0) && (r_disp_tens == '0) && (r_disp_ones == '0);
    assign w_reject    = (r_disp_tens > SEC_TENS_MAX) || (r_disp_min > MIN_MAX);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_disp_min  <= '0;
            r_disp_tens <= '0;
            r_disp_ones <= '0;
            r_load_min  <= '0;
            r_load_tens <= '0;
            r_load_ones <= '0;
            r_count     <= '0;
            r_loadn     <= 1'b1;
            r_run_en    <= 1'b0;
            r_entry_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_disp_min  <= w_disp_min_nxt;
            r_disp_tens <= w_disp_tens_nxt;
            r_disp_ones <= w_disp_ones_nxt;
            r_load_min  <= w_load_min_nxt;
            r_load_tens <= w_load_tens_nxt;
            r_load_ones <= w_load_ones_nxt;
            r_count     <= w_count_nxt;
            r_loadn     <= w_loadn_nxt;
            r_run_en    <= w_run_en_nxt;
            r_entry_err <= w_entry_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Every output is the registered image of its next value, so loadn is low
    // exactly for the cycle spent in LOAD and entry_err lands one cycle after its cause.
    always_comb begin
        w_state_nxt     = r_state;
        w_disp_min_nxt  = r_disp_min;
        w_disp_tens_nxt = r_disp_tens;
        w_disp_ones_nxt = r_disp_ones;
        w_load_min_nxt  = r_load_min;
        w_load_tens_nxt = r_load_tens;
        w_load_ones_nxt = r_load_ones;
        w_count_nxt     = r_count;
        w_loadn_nxt     = 1'b1;
        w_run_en_nxt    = 1'b0;
        w_entry_err_nxt = 1'b0;

        if (cancel) begin
            w_state_nxt     = S_IDLE;
            w_disp_min_nxt  = '0;
            w_disp_tens_nxt = '0;
            w_disp_ones_nxt = '0;
            w_load_min_nxt  = '0;
            w_load_tens_nxt = '0;
            w_load_ones_nxt = '0;
            w_count_nxt     = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ENTRY: begin
                    if (start) begin
                        if (!w_buf_zero) begin
                            if (w_reject) begin
                                w_entry_err_nxt = 1'b1;
                                w_state_nxt     = S_IDLE;
                                w_disp_min_nxt  = '0;
                                w_disp_tens_nxt = '0;
                                w_disp_ones_nxt = '0;
                                w_count_nxt     = '0;
                            end else begin
                                w_state_nxt     = S_LOAD;
                                w_load_min_nxt  = r_disp_min;
                                w_load_tens_nxt = r_disp_tens;
                                w_load_ones_nxt = r_disp_ones;
                                w_loadn_nxt     = 1'b0;
                            end
                        end
                    end else if (key_valid) begin
                        if (!w_key_legal) begin
                            w_entry_err_nxt = 1'b1;
                        end else if (r_count != 2'd3) begin
                            w_disp_min_nxt  = r_disp_tens;
                            w_disp_tens_nxt = r_disp_ones;
                            w_disp_ones_nxt = key_digit;
                            w_count_nxt     = r_count + 2'd1;
                            w_state_nxt     = S_ENTRY;
                        end
                    end
                end
                S_LOAD: begin
                    w_state_nxt  = S_RUN;
                    w_run_en_nxt = 1'b1;
                end
                S_RUN: begin
                    if (timer_zero) begin
                        w_state_nxt     = S_IDLE;
                        w_disp_min_nxt  = '0;
                        w_disp_tens_nxt = '0;
                        w_disp_ones_nxt = '0;
                        w_count_nxt     = '0;
                    end else begin
                        w_run_en_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
    end

    assign disp_min  = r_disp_min;
    assign disp_tens = r_disp_tens;
    assign disp_ones = r_disp_ones;
    assign load_min  = r_load_min;
    assign load_tens = r_load_tens;
    assign load_ones = r_load_ones;
    assign loadn     = r_loadn;
    assign run_en    = r_run_en;
    assign entry_err = r_entry_err;
    assign busy      = r_busy;

endmodule
